// File: rtl/stream_sel_mux.sv
// stream_sel_mux: selects one of NUM_IN valid/ready input streams onto a single
// registered output stream. mode=0 uses the external select index, mode=1 uses
// round-robin arbitration starting after the last round-robin grant.
// Optional packet locking is enabled by defining STREAM_SEL_MUX_PKT_LOCK_EN:
// adds in_last/out_last and holds the grant on one channel until its last beat.
module stream_sel_mux #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 4,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_last,
`endif
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        grant
);

  // Output register stage (p1) and round-robin pointer
  logic              vld_p1;
  logic [WIDTH-1:0]  data_p1;
  logic [SEL_W-1:0]  grant_p1;
  logic [SEL_W-1:0]  rr_last;

  logic              load;
  logic              man_ok;
  logic              rr_ok;
  logic [SEL_W-1:0]  rr_idx;
  int                rr_best;
  int                rr_dist;
  logic              cand_ok;
  logic [SEL_W-1:0]  cand;
  logic [WIDTH-1:0]  cand_data;

`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
  logic              locked;
  logic [SEL_W-1:0]  lock_ch;
  logic              lock_ok;
  logic              cand_last;
  logic              last_p1;
`endif

  // The register may take a new beat when it is empty or being drained
  assign load = !vld_p1 || out_ready;

  // Manual candidate exists only for an in-range select whose channel is valid
  always_comb begin
    man_ok = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if ((select == SEL_W'(i)) && in_valid[i]) man_ok = 1'b1;
    end
  end

  // Round-robin: the valid channel with the smallest distance after rr_last wins
  always_comb begin
    rr_best = NUM_IN;
    rr_dist = 0;
    rr_idx  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_valid[i]) begin
        rr_dist = (i + NUM_IN - 1 - int'(rr_last)) % NUM_IN;
        if (rr_dist < rr_best) begin
          rr_best = rr_dist;
          rr_idx  = SEL_W'(i);
        end
      end
    end
    rr_ok = (rr_best < NUM_IN);
  end

`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
  // While locked only the locked channel may supply the next beat
  always_comb begin
    lock_ok = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if ((lock_ch == SEL_W'(i)) && in_valid[i]) lock_ok = 1'b1;
    end
  end
`endif

  // Candidate choice: lock overrides mode; otherwise manual or round-robin
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
    if (locked) begin
      cand    = lock_ch;
      cand_ok = lock_ok;
    end else
`endif
    if (mode) begin
      cand    = rr_idx;
      cand_ok = rr_ok;
    end else begin
      cand    = select;
      cand_ok = man_ok;
    end
  end

  // Route the candidate's data (and last flag) to the register input
  always_comb begin
    cand_data = '0;
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
    cand_last = 1'b0;
`endif
    for (int i = 0; i < NUM_IN; i++) begin
      if (cand == SEL_W'(i)) begin
        cand_data = in_data[i*WIDTH +: WIDTH];
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
        cand_last = in_last[i];
`endif
      end
    end
  end

  // One-hot accept towards the chosen producer; silent while in reset
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = !rst && load && cand_ok && (cand == SEL_W'(i));
    end
  end

  // ---- stage p1: output register, updated whenever load is high ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      grant_p1 <= '0;
      rr_last  <= SEL_W'(NUM_IN - 1);
    end else if (load) begin
      vld_p1 <= cand_ok;
      if (cand_ok) begin
        data_p1  <= cand_data;
        grant_p1 <= cand;
        if (mode) rr_last <= cand;
      end
    end
  end

`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
  // Lock onto a channel after a non-last beat; release after its last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
      last_p1 <= 1'b0;
    end else if (load && cand_ok) begin
      locked  <= !cand_last;
      lock_ch <= cand;
      last_p1 <= cand_last;
    end
  end

  assign out_last = last_p1;
`endif

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign grant     = grant_p1;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Testbench for stream_sel_mux (NUM_IN=4, WIDTH=8): directed scenarios with
// literal expectations, then randomized traffic checked every cycle against a
// behavioural model. Packet-lock checks compile in with STREAM_SEL_MUX_PKT_LOCK_EN.
module tb_stream_sel_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic           mode = 1'b1;
  logic [1:0]     select = '0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [1:0]     grant;
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
  logic [N-1:0]   in_last = '0;
  logic           out_last;
`endif

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stream_sel_mux #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
    .in_last(in_last),
    .out_last(out_last),
`endif
    .mode(mode),
    .select(select),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant(grant)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: current (m_) and next (n_) output-register contents
  int         m_last = N - 1, n_last = N - 1;
  bit         m_vld = 0, n_vld = 0;
  logic [7:0] m_data = '0, n_data = '0;
  int         m_grant = 0, n_grant = 0;
  bit         m_lock = 0, n_lock = 0;
  int         m_lch = 0, n_lch = 0;
  bit         m_olast = 0, n_olast = 0;

  // Compare DUT against the model mid-cycle and compute the model's next state
  always @(negedge clk) begin : model_cmp
    int         cand;
    bit         ld;
    logic [N-1:0] erdy;
    cand = -1;
    ld   = !m_vld || out_ready;
    erdy = '0;
    if (!rst) begin
      if (m_lock) begin
        if (in_valid[m_lch]) cand = m_lch;
      end else if (!mode) begin
        if (int'(select) < N && in_valid[select]) cand = int'(select);
      end else begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (cand < 0 && in_valid[idx]) cand = idx;
        end
      end
      if (ld && cand >= 0) erdy[cand] = 1'b1;
    end
    chk("in_ready", 32'(in_ready), 32'(erdy));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("grant", 32'(grant), 32'(m_grant));
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
    chk("out_last", 32'(out_last), 32'(m_olast));
`endif
    n_last = m_last; n_vld = m_vld; n_data = m_data; n_grant = m_grant;
    n_lock = m_lock; n_lch = m_lch; n_olast = m_olast;
    if (rst) begin
      n_last = N - 1; n_vld = 0; n_data = '0; n_grant = 0;
      n_lock = 0; n_lch = 0; n_olast = 0;
    end else if (ld) begin
      n_vld = (cand >= 0);
      if (cand >= 0) begin
        n_data  = in_data[cand*W +: W];
        n_grant = cand;
        if (mode) n_last = cand;
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
        n_lock  = !in_last[cand];
        n_lch   = cand;
        n_olast = in_last[cand];
`endif
      end
    end
  end

  always @(posedge clk) begin
    m_last = n_last; m_vld = n_vld; m_data = n_data; m_grant = n_grant;
    m_lock = n_lock; m_lch = n_lch; m_olast = n_olast;
  end

  int rr_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset with every channel requesting
    rst = 1'b1; mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(17 * (i + 1));
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_in_ready", 32'(in_ready), 0);

    // Round-robin with all channels valid: 0,1,2,3,0 back to back
    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(rr_seq[j]));
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_data", 32'(out_data), 32'(8'(17 * (rr_seq[j] + 1))));
    end

    // Backpressure: 8'h3C must hold for 5 stalled cycles
    mode = 1'b0; select = 2'd1; in_valid = 4'b0010; in_data[1*W +: W] = 8'h3C;
    tick();
    chk("bp_load", 32'(out_data), 32'h3C);
    out_ready = 1'b0; in_data[1*W +: W] = 8'h77;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("bp_hold_data", 32'(out_data), 32'h3C);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("bp_next_data", 32'(out_data), 32'h77);

    // Manual select of channel 2
    select = 2'd2; in_valid = 4'b0100; in_data[2*W +: W] = 8'hA5;
    #1;
    chk("man_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("man_data", 32'(out_data), 32'hA5);
    chk("man_valid", 32'(out_valid), 1);
    chk("man_grant", 32'(grant), 2);

    // Manual select of an idle channel: nothing granted, output drains
    select = 2'd1; in_valid = 4'b0001;
    #1;
    chk("idle_ready", 32'(in_ready), 0);
    tick();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_grant_hold", 32'(grant), 2);
    chk("idle_data_hold", 32'(out_data), 32'hA5);
    tick();
    chk("idle_valid2", 32'(out_valid), 0);

`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
    // Three-beat packet on channel 1 keeps the grant despite channels 0 and 2
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b1; in_valid = 4'b0010; in_last = 4'b0000;
    #1;
    chk("lock_ready1", 32'(in_ready), 32'b0010);
    tick();
    chk("lock_grant1", 32'(grant), 1);
    in_valid = 4'b0111;
    #1;
    chk("lock_ready2", 32'(in_ready), 32'b0010);
    tick();
    chk("lock_grant2", 32'(grant), 1);
    in_last = 4'b0010;
    tick();
    chk("lock_grant3", 32'(grant), 1);
    chk("lock_out_last", 32'(out_last), 1);
    in_last = 4'b0000;
    tick();
    chk("lock_after", 32'(grant), 2);
`endif

    // Randomized traffic, including occasional mid-stream reset
    for (int j = 0; j < 2000; j++) begin
      rst       = ($urandom_range(99) == 0);
      in_valid  = 4'($urandom);
      mode      = 1'($urandom_range(1));
      select    = 2'($urandom_range(3));
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
`ifdef STREAM_SEL_MUX_PKT_LOCK_EN
      in_last   = 4'($urandom);
`endif
      tick();
    end
    rst = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/stream_sel_mux.md
Name: stream_sel_mux

Overview:
- Parametrised successor of the team's 4:1 combinational select mux.
- Selects one of NUM_IN streaming input channels, each WIDTH bits with valid/ready handshake, onto one registered output stream.
- Two run-time selection modes: manual (external select, like the old mux) and round-robin arbitration.
- Sits between multiple producer units and a shared consumer (e.g. register-file write port or bus master).

Parameters:
- NUM_IN, 4, number of input channels (2..16).
- WIDTH, 4, data width per channel in bits (1..64).
- SEL_W, derived localparam = max(1, clog2(NUM_IN)), width of select/grant fields. Not user-overridable.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel data valid.
- in_ready  output  NUM_IN  per-channel accept (combinational).
- mode  input  1  0 = manual select, 1 = round-robin.
- select  input  SEL_W  channel index used in manual mode.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer accept.
- grant  output  SEL_W  index of channel whose beat is currently in the output register.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. The polarity and synchronicity of rst are fixed.
- Reset values:
  - out_valid = 0, out_data = 0, grant = 0.
  - Round-robin pointer last = NUM_IN-1, so channel 0 has first priority after reset.
  - Lock state (if present) cleared.
- Load enable: load = !out_valid || out_ready.
  - Single register stage.
  - Latency 1 cycle from acceptance to out_valid.
  - Sustained throughput 1 beat/cycle when out_ready is held high.
- Candidate selection (combinational, every cycle):
  - Manual mode: cand = select. No candidate if select >= NUM_IN or in_valid[select] = 0.
  - Round-robin mode: cand = first i with in_valid[i] = 1, searching last+1, last+2, ... with wrap modulo NUM_IN. No candidate if no valid inputs.
- Handshake:
  - in_ready[i] = load && candidate exists && cand == i.
  - All other in_ready bits = 0; at most one in_ready bit high per cycle.
  - in_ready must never depend on in_valid of the same channel in manual mode, beyond the cand-exists term.
- Transfer (in_valid[cand] && in_ready[cand]):
  - Next cycle: out_data = in_data[cand], out_valid = 1, grant = cand.
  - If in round-robin mode, last = cand. Manual-mode transfers do not move last.
- load = 1 with no candidate: out_valid -> 0; out_data and grant hold their previous value.
- Output stall (out_valid = 1, out_ready = 0): out_data, out_valid and grant hold; all in_ready = 0.
- A mode or select change takes effect in the same cycle's candidate calculation. A beat already in the output register is unaffected.
- Simultaneous drain and fill (out_valid && out_ready && new transfer): the register is replaced with no bubble.
- rst asserted mid-stream: the pending output beat is discarded and the pointer is reset. Producers see in_ready = 0 during the reset cycle.

Optional Feature:
- Macro: STREAM_SEL_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, NUM_IN) and out_last (output, 1, reset 0, registered with out_data).
  - After a transfer with in_last[cand] = 0, the arbiter locks to that channel. mode, select and round-robin are ignored; cand = locked channel, and no candidate is produced until it is valid.
  - Lock releases after the transfer carrying in_last = 1.
  - rst clears the lock.
- Undefined:
  - No last ports.
  - Arbitration is per beat as above.

Test Plan:
- Reset: rst high 2 cycles with all in_valid = 4'b1111 -> out_valid = 0, out_data = 0, grant = 0, in_ready = 0; first post-reset round-robin grant = 0.
- Manual mode, NUM_IN = 4, WIDTH = 8, select = 2, in_data ch2 = 8'hA5, in_valid = 4'b0100, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 8'hA5, out_valid = 1, grant = 2.
- Round-robin, all 4 channels valid continuously, out_ready = 1 -> grant sequence 0, 1, 2, 3, 0; one beat per cycle, no bubbles.
- Backpressure: out_valid = 1 with 8'h3C, out_ready = 0 for 5 cycles -> out_data stays 8'h3C, in_ready = 0; on out_ready = 1 the next beat appears the following cycle.
- Manual select = 1 with in_valid[1] = 0 and in_valid[0] = 1 -> in_ready = 0; out_valid drops after the current beat drains; channel 0 is not granted.
- With STREAM_SEL_MUX_PKT_LOCK_EN: ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 are valid in round-robin -> grant = 1 for 3 consecutive beats, then the next grant is 2.
